// File: rtl/int_dispatch_if.sv
// -----------------------------------------------------------------------------
// int_dispatch_if
//   Bundles the sequencer/bus-side signals of the interrupt dispatcher.
//
//   Handshake: there is no valid/ready pair. m_cycle is a one-clock strobe and
//   the only qualifier. Every input is sampled, and every state change happens,
//   on a clk edge where m_cycle=1. insn_done and op_* count only on such an
//   edge. wr_enable, sp_dec, addr, data_out and new_pc hold for the whole
//   M-cycle. pc_load and int_clear are high only on the clock where m_cycle=1.
//
//   master : the sequencer / register-file side (drives m_cycle, insn_done,
//            op_*, int_pending, pc, sp)
//   slave  : the dispatcher (drives addr, data_out, wr_enable, sp_dec, pc_load,
//            new_pc, int_clear, ime, halted, busy, dbg_state)
// -----------------------------------------------------------------------------
interface int_dispatch_if;
   logic        m_cycle;
   logic        insn_done;
   logic        op_ei;
   logic        op_di;
   logic        op_reti;
   logic        op_halt;
   logic [7:0]  int_pending;
   logic [15:0] pc;
   logic [15:0] sp;
   logic [15:0] addr;
   logic [7:0]  data_out;
   logic        wr_enable;
   logic        sp_dec;
   logic        pc_load;
   logic [15:0] new_pc;
   logic [7:0]  int_clear;
   logic        ime;
   logic        halted;
   logic        busy;
   logic [2:0]  dbg_state;

   modport master (
      output m_cycle, insn_done, op_ei, op_di, op_reti, op_halt,
      output int_pending, pc, sp,
      input  addr, data_out, wr_enable, sp_dec, pc_load, new_pc,
      input  int_clear, ime, halted, busy, dbg_state
   );

   modport slave (
      input  m_cycle, insn_done, op_ei, op_di, op_reti, op_halt,
      input  int_pending, pc, sp,
      output addr, data_out, wr_enable, sp_dec, pc_load, new_pc,
      output int_clear, ime, halted, busy, dbg_state
   );
endinterface

// File: rtl/int_dispatch.sv
// -----------------------------------------------------------------------------
// int_dispatch
//   CPU-side interrupt responder. It holds the master enable (IME), handles
//   HALT wake-up and runs the 5 M-cycle interrupt entry:
//   WAIT0, WAIT1, PUSH_HI, PUSH_LO, JUMP.
//
//   Ports:
//     clk  - system clock
//     rst  - asynchronous active-high reset
//     bus  - int_dispatch_if.slave. Its inputs are m_cycle, insn_done, op_*,
//            int_pending, pc and sp. Its outputs are the push bus
//            (addr/data_out/wr_enable/sp_dec), the vector load
//            (pc_load/new_pc), the int_clear pulse, ime, halted and busy.
//            dbg_state exposes the FSM state.
// -----------------------------------------------------------------------------
module int_dispatch #(
   parameter int          NUM_IRQ       = 5,
   parameter logic [15:0] VECTOR_BASE   = 16'h0040,
   parameter int          VECTOR_STRIDE = 8
) (
   input  logic          clk,
   input  logic          rst,
   int_dispatch_if.slave bus
);

   localparam int          IDX_W    = 3;
   localparam logic [15:0] STRIDE16 = 16'(VECTOR_STRIDE);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_WAIT0   = 3'd1,
      S_WAIT1   = 3'd2,
      S_PUSH_HI = 3'd3,
      S_PUSH_LO = 3'd4,
      S_JUMP    = 3'd5
   } state_t;

   state_t             state;
   logic               ime_q;
   logic               ei_armed;
   logic               halted_q;
   logic               prio_valid;
   logic [IDX_W-1:0]   prio_idx;

   logic [NUM_IRQ-1:0] pend_lo;
   logic               pend_found;
   logic [IDX_W-1:0]   pend_idx;
   logic               start;

   assign pend_lo = bus.int_pending[NUM_IRQ-1:0];

   generate
      if (NUM_IRQ < 8) begin : g_unused_pending
         logic unused_pending_hi;
         assign unused_pending_hi = ^bus.int_pending[7:NUM_IRQ];
      end
   endgenerate

   // Lowest set bit wins: scan from the top so the last hit is the lowest bit.
   always_comb begin
      pend_found = 1'b0;
      pend_idx   = '0;
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
         if (pend_lo[i]) begin
            pend_found = 1'b1;
            pend_idx   = i[IDX_W-1:0];
         end
      end
   end

   // Uses the IME value from before this edge. A DI retiring on the same
   // boundary cancels the entry.
   assign start = bus.m_cycle && (state == S_IDLE) && ime_q && pend_found &&
                  (bus.insn_done || halted_q) && !(bus.insn_done && bus.op_di);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         ime_q      <= 1'b0;
         ei_armed   <= 1'b0;
         halted_q   <= 1'b0;
         prio_valid <= 1'b0;
         prio_idx   <= '0;
      end else if (bus.m_cycle) begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  state    <= S_WAIT0;
                  ime_q    <= 1'b0;
                  ei_armed <= 1'b0;
                  halted_q <= 1'b0;
               end else begin
                  // Any pending request wakes HALT, even with IME clear.
                  if (halted_q && pend_found) halted_q <= 1'b0;
                  if (bus.insn_done) begin
                     if (bus.op_di) begin
                        ime_q    <= 1'b0;
                        ei_armed <= 1'b0;
                     end else begin
                        // EI takes effect one instruction late.
                        if (ei_armed) begin
                           ime_q    <= 1'b1;
                           ei_armed <= 1'b0;
                        end
                        if (bus.op_reti) ime_q    <= 1'b1;
                        if (bus.op_ei)   ei_armed <= 1'b1;
                     end
                     if (bus.op_halt) halted_q <= 1'b1;
                  end
               end
            end
            S_WAIT0:   state <= S_WAIT1;
            S_WAIT1:   state <= S_PUSH_HI;
            S_PUSH_HI: state <= S_PUSH_LO;
            S_PUSH_LO: begin
               // The request may have been withdrawn during entry. In that
               // case the jump goes to 0 and nothing is cleared.
               prio_valid <= pend_found;
               prio_idx   <= pend_idx;
               state      <= S_JUMP;
            end
            S_JUMP:    state <= S_IDLE;
            default:   state <= S_IDLE;
         endcase
      end
   end

   always_comb begin
      bus.addr      = 16'h0000;
      bus.data_out  = 8'h00;
      bus.wr_enable = 1'b0;
      bus.sp_dec    = 1'b0;
      bus.pc_load   = 1'b0;
      bus.new_pc    = 16'h0000;
      bus.int_clear = 8'h00;
      case (state)
         S_PUSH_HI: begin
            bus.addr      = bus.sp - 16'd1;
            bus.data_out  = bus.pc[15:8];
            bus.wr_enable = 1'b1;
            bus.sp_dec    = 1'b1;
         end
         S_PUSH_LO: begin
            // sp has already been decremented by the register file.
            bus.addr      = bus.sp - 16'd1;
            bus.data_out  = bus.pc[7:0];
            bus.wr_enable = 1'b1;
            bus.sp_dec    = 1'b1;
         end
         S_JUMP: begin
            if (prio_valid) bus.new_pc = VECTOR_BASE + ({13'd0, prio_idx} * STRIDE16);
            if (bus.m_cycle) begin
               bus.pc_load = 1'b1;
               if (prio_valid) bus.int_clear = 8'b1 << prio_idx;
            end
         end
         default: ;
      endcase
   end

   assign bus.busy      = (state != S_IDLE);
   assign bus.ime       = ime_q;
   assign bus.halted    = halted_q;
   assign bus.dbg_state = state;

endmodule
